// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR polynomial, checker FSM encoding and next-value helper
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 4;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 4'b0011;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
    input logic [LFSR_WIDTH-1:0] q,
    input logic [LFSR_WIDTH-1:0] taps
  );
    return {q[LFSR_WIDTH-2:0], 1'b0} ^ (q[LFSR_WIDTH-1] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_checker_step.sv
// rtl/lfsr_checker_step.sv - combinational one-step Galois LFSR advance
module lfsr_step #(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b0011
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  assign q_next = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising LFSR sequence checker with lock and error count
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH      = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned LOSS_COUNT = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_q,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] error_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);

  lfsr_state_e        state, state_nxt;
  logic [WIDTH-1:0]   pred, pred_nxt;
  logic [MATCH_W-1:0] match_cnt, match_cnt_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_cnt_nxt;
  logic               locked_nxt, err_nxt;
  logic [CNT_W-1:0]   error_count_nxt;
  logic [WIDTH-1:0]   step_in, step_out;

  // Once locked the checker free-runs on its own prediction instead of the data.
  assign step_in = (state == LOCKED) ? pred : in_q;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .q      (step_in),
    .q_next (step_out)
  );

  always_comb begin
    state_nxt       = state;
    pred_nxt        = pred;
    match_cnt_nxt   = match_cnt;
    miss_cnt_nxt    = miss_cnt;
    locked_nxt      = locked;
    err_nxt         = 1'b0;
    error_count_nxt = error_count;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_q != '0) begin
            pred_nxt      = step_out;
            match_cnt_nxt = '0;
            state_nxt     = SYNC;
          end
        end
        SYNC: begin
          if (in_q == '0) begin
            state_nxt = HUNT;
          end else if (in_q == pred) begin
            pred_nxt = step_out;
            if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
              match_cnt_nxt = '0;
              state_nxt     = LOCKED;
              locked_nxt    = 1'b1;
            end else begin
              match_cnt_nxt = match_cnt + 1'b1;
            end
          end else begin
            pred_nxt      = step_out;
            match_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          pred_nxt = step_out;
          if (in_q == pred) begin
            miss_cnt_nxt = '0;
          end else begin
            err_nxt = 1'b1;
            if (error_count != {CNT_W{1'b1}}) error_count_nxt = error_count + 1'b1;
            if (miss_cnt == MISS_W'(LOSS_COUNT - 1)) begin
              miss_cnt_nxt = '0;
              state_nxt    = HUNT;
              locked_nxt   = 1'b0;
            end else begin
              miss_cnt_nxt = miss_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      pred        <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      error_count <= '0;
    end else begin
      state       <= state_nxt;
      pred        <= pred_nxt;
      match_cnt   <= match_cnt_nxt;
      miss_cnt    <= miss_cnt_nxt;
      locked      <= locked_nxt;
      err         <= err_nxt;
      error_count <= error_count_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_q = 4'h0;
  logic       locked, err;
  logic [7:0] error_count;

  logic       in_valid2 = 1'b0;
  logic [3:0] in_q2 = 4'h0;
  logic       locked2, err2;
  logic [1:0] error_count2;

  int checks = 0;
  int failures = 0;

  logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                           4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

  always #5 clk = ~clk;

  lfsr_checker u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_q        (in_q),
    .locked      (locked),
    .err         (err),
    .error_count (error_count)
  );

  lfsr_checker #(.CNT_W(2), .LOSS_COUNT(100)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid2),
    .in_q        (in_q2),
    .locked      (locked2),
    .err         (err2),
    .error_count (error_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] q);
    @(negedge clk);
    in_valid = v;
    in_q = q;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic [3:0] q);
    @(negedge clk);
    in_valid2 = 1'b1;
    in_q2 = q;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input logic l, input logic e, input logic [7:0] c);
    chk({tag, "_locked"}, 32'(locked), 32'(l));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_count"}, 32'(error_count), 32'(c));
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #3;
    expect3("reset", 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Clean lock
    drive(1, 4'h1); expect3("lock_w1", 0, 0, 0);
    drive(1, 4'h2); expect3("lock_w2", 0, 0, 0);
    drive(1, 4'h4); expect3("lock_w3", 0, 0, 0);
    drive(1, 4'h8); expect3("lock_w4", 1, 0, 0);
    drive(1, 4'h3); expect3("lock_w5", 1, 0, 0);

    // Single error while locked
    drive(1, 4'h0); expect3("single_bad", 1, 1, 1);
    drive(1, 4'hC); expect3("single_next", 1, 0, 1);

    // Loss of lock: 1011 and 0101 expected
    drive(1, 4'hF); expect3("loss_1", 1, 1, 2);
    drive(1, 4'hF); expect3("loss_2", 0, 1, 3);
    drive(0, 4'h0); expect3("loss_gap", 0, 0, 3);
    drive(1, 4'h5); drive(1, 4'hA); drive(1, 4'h7);
    expect3("relock_w3", 0, 0, 3);
    drive(1, 4'hE); expect3("relock_w4", 1, 0, 3);

    // Gaps and wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, seq[i]);
      expect3($sformatf("wrap_w%0d", i), (i >= 3), 0, 0);
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        drive(0, 4'h0);
        expect3($sformatf("wrap_gap%0d", i), (i >= 3), 0, 0);
      end
    end

    // Async reset between edges, with nonzero state
    drive(1, 4'h0); expect3("pre_async", 1, 1, 1);
    #2;
    reset = 1'b0;
    #1;
    expect3("async_reset", 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;

    // HUNT/SYNC robustness
    drive(1, 4'h0); drive(1, 4'h0); expect3("hunt_zeros", 0, 0, 0);
    drive(1, 4'h5); drive(1, 4'hA);
    drive(1, 4'hF); expect3("sync_reseed", 0, 0, 0);
    drive(1, 4'hD); drive(1, 4'h9); expect3("sync_m2", 0, 0, 0);
    drive(1, 4'h1); expect3("sync_lock", 1, 0, 0);

    // Saturation on the narrow-counter instance
    drive2(4'h1); drive2(4'h2); drive2(4'h4); drive2(4'h8);
    chk("sat_locked", 32'(locked2), 32'd1);
    drive2(4'h0); chk("sat_c1", 32'(error_count2), 32'd1);
    drive2(4'h0); chk("sat_c2", 32'(error_count2), 32'd2);
    drive2(4'h0); chk("sat_c3", 32'(error_count2), 32'd3);
    drive2(4'h0); chk("sat_c4", 32'(error_count2), 32'd3);
    drive2(4'h0); chk("sat_c5", 32'(error_count2), 32'd3);
    chk("sat_err", 32'(err2), 32'd1);
    chk("sat_still_locked", 32'(locked2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
